// File: rtl/sd_readout_chunk_serializer.sv
// rtl/sd_readout_chunk_serializer.sv - FIFO-buffered chunk serializer from SD readout words to 1/2/4/8-bit SPI lanes
module sd_readout_chunk_serializer #(
  parameter int WORD_W      = 16,
  parameter int LANES       = 4,
  parameter int DEPTH       = 64,
  parameter int CHUNK_WORDS = 16,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   en,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   out_shift,
  output logic [LANES-1:0]       out_data,
  output logic                   d_ready,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int BEATS = WORD_W / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WLW   = (CHUNK_WORDS > 1) ? $clog2(CHUNK_WORDS) : 1;

  localparam logic [BW-1:0]  LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [FW-1:0]  FILL_CHUNK = FW'(CHUNK_WORDS);
  localparam logic [FW-1:0]  FILL_FULL  = FW'(DEPTH);
  localparam logic [WLW-1:0] FIRST_LEFT = WLW'(CHUNK_WORDS - 1);

  if ((WORD_W % LANES) != 0) begin : g_bad_word_w
    $error("WORD_W must be a multiple of LANES");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4 or 8");
  end
  if (CHUNK_WORDS > DEPTH || CHUNK_WORDS < 1) begin : g_bad_chunk
    $error("CHUNK_WORDS must be in 1..DEPTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WORD_W-1:0] sr;
  logic [BW-1:0]     beat;
  logic [WLW-1:0]    words_left;

  logic push, pop, start, shift_ev, last_beat, more_words;

  assign wr_ready   = rst_ & en & (fill < FILL_FULL);
  assign push       = wr_valid & wr_ready;
  assign start      = (state == S_IDLE) && (fill >= FILL_CHUNK);
  assign shift_ev   = out_shift && (state != S_IDLE);
  assign last_beat  = (beat == LAST_BEAT);
  assign more_words = (words_left != '0);

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= S_IDLE;
    end else if (!en) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_READY;
      end
      S_READY, S_XFER: begin
        if (shift_ev) begin
          state_nxt = (last_beat && !more_words) ? S_IDLE : S_XFER;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; the last-beat refill pops in the same cycle as the shift
  always_comb begin
    d_ready  = (state == S_READY);
    out_data = '0;
    pop      = start || (shift_ev && last_beat && more_words);
    if (state != S_IDLE) begin
      out_data = LSB_FIRST ? sr[LANES-1:0] : sr[WORD_W-1 -: LANES];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      sr         <= '0;
      beat       <= '0;
      words_left <= '0;
      underrun   <= 1'b0;
    end else if (!en) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      sr         <= '0;
      beat       <= '0;
      words_left <= '0;
      underrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase

      if (state == S_IDLE && out_shift) underrun <= 1'b1;

      if (start) begin
        sr         <= mem[rd_ptr];
        beat       <= '0;
        words_left <= FIRST_LEFT;
      end else if (shift_ev) begin
        if (last_beat) begin
          beat <= '0;
          if (more_words) begin
            sr         <= mem[rd_ptr];
            words_left <= words_left - 1'b1;
          end else begin
            sr <= '0;
          end
        end else begin
          sr   <= LSB_FIRST ? (sr >> LANES) : (sr << LANES);
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_readout_chunk_serializer.sv
// tb/tb_sd_readout_chunk_serializer.sv - directed and scoreboarded bench for sd_readout_chunk_serializer
module tb_sd_readout_chunk_serializer;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        en = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        out_shift = 1'b0;
  int          sel = 0;

  int checks = 0;
  int failures = 0;

  logic [15:0] gw [16];

  logic       a_wr_ready, b_wr_ready, c_wr_ready_i, d_wr_ready;
  logic [3:0] a_out;
  logic [0:0] b_out;
  logic [7:0] c_out_i;
  logic [1:0] d_out;
  logic       a_dr, b_dr, c_dr, d_dr;
  logic       a_ur, b_ur, c_ur, d_ur;
  logic [6:0] a_fill;
  logic [3:0] b_fill;
  logic [2:0] c_fill_i;
  logic [4:0] d_fill;

  logic       c_wr_ready, c_d_ready, c_underrun;
  logic [7:0] c_out;
  logic [7:0] c_fill;

  always #5 clk = ~clk;

  sd_readout_chunk_serializer dut_a (
    .clk(clk), .rst_(rst_), .en(en), .wr_data(wr_data), .wr_valid(wr_valid && sel == 0),
    .wr_ready(a_wr_ready), .out_shift(out_shift && sel == 0), .out_data(a_out),
    .d_ready(a_dr), .underrun(a_ur), .fill(a_fill));

  sd_readout_chunk_serializer #(.WORD_W(16), .LANES(1), .DEPTH(8), .CHUNK_WORDS(4), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_(rst_), .en(en), .wr_data(wr_data), .wr_valid(wr_valid && sel == 1),
    .wr_ready(b_wr_ready), .out_shift(out_shift && sel == 1), .out_data(b_out),
    .d_ready(b_dr), .underrun(b_ur), .fill(b_fill));

  sd_readout_chunk_serializer #(.WORD_W(16), .LANES(8), .DEPTH(4), .CHUNK_WORDS(4), .LSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst_(rst_), .en(en), .wr_data(wr_data), .wr_valid(wr_valid && sel == 2),
    .wr_ready(c_wr_ready_i), .out_shift(out_shift && sel == 2), .out_data(c_out_i),
    .d_ready(c_dr), .underrun(c_ur), .fill(c_fill_i));

  sd_readout_chunk_serializer #(.WORD_W(16), .LANES(2), .DEPTH(16), .CHUNK_WORDS(8), .LSB_FIRST(1'b1)) dut_d (
    .clk(clk), .rst_(rst_), .en(en), .wr_data(wr_data), .wr_valid(wr_valid && sel == 3),
    .wr_ready(d_wr_ready), .out_shift(out_shift && sel == 3), .out_data(d_out),
    .d_ready(d_dr), .underrun(d_ur), .fill(d_fill));

  always_comb begin
    c_wr_ready = a_wr_ready; c_out = 8'(a_out); c_d_ready = a_dr; c_underrun = a_ur; c_fill = 8'(a_fill);
    case (sel)
      1: begin c_wr_ready = b_wr_ready; c_out = 8'(b_out); c_d_ready = b_dr; c_underrun = b_ur; c_fill = 8'(b_fill); end
      2: begin c_wr_ready = c_wr_ready_i; c_out = c_out_i; c_d_ready = c_dr; c_underrun = c_ur; c_fill = 8'(c_fill_i); end
      3: begin c_wr_ready = d_wr_ready; c_out = 8'(d_out); c_d_ready = d_dr; c_underrun = d_ur; c_fill = 8'(d_fill); end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    bit ok = 1'b0;
    wr_data = w;
    wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = c_wr_ready;
      step();
    end
    wr_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL push_timeout word=%h not accepted", w);
    end
  endtask

  task automatic shift_beat();
    out_shift = 1'b1;
    step();
    out_shift = 1'b0;
  endtask

  task automatic wait_d_ready(input string name);
    int n = 0;
    while (!c_d_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (c_d_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s d_ready never rose, got=%b want=1", name, c_d_ready);
    end
  endtask

  task automatic test_reset();
    sel = 0; rst_ = 1'b0; en = 1'b1;
    step(); step();
    checks++; if (c_wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b want=0", c_wr_ready); end
    checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL reset_d_ready got=%b want=0", c_d_ready); end
    checks++; if (c_out !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h want=00", c_out); end
    checks++; if (c_fill !== 8'd0) begin failures++; $display("FAIL reset_fill got=%0d want=0", c_fill); end
    rst_ = 1'b1;
    step();
    checks++; if (c_wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_wr_ready got=%b want=1", c_wr_ready); end
  endtask

  task automatic test_chunk_gating();
    sel = 0;
    gw[0] = 16'hA5C3;
    for (int i = 1; i < 15; i++) gw[i] = 16'h1000 + 16'(i);
    gw[15] = 16'h1234;
    for (int i = 0; i < 15; i++) push(gw[i]);
    step(); step();
    checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL gating_15_d_ready got=%b want=0", c_d_ready); end
    checks++; if (c_fill !== 8'd15) begin failures++; $display("FAIL gating_15_fill got=%0d want=15", c_fill); end
    wr_data = gw[15]; wr_valid = 1'b1;
    step();
    wr_data = 16'hBEEF;
    checks++; if (c_fill !== 8'd16) begin failures++; $display("FAIL gating_n1_fill got=%0d want=16", c_fill); end
    checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL gating_n1_d_ready got=%b want=0", c_d_ready); end
    step();
    wr_valid = 1'b0;
    checks++; if (c_d_ready !== 1'b1) begin failures++; $display("FAIL gating_n2_d_ready got=%b want=1", c_d_ready); end
    checks++; if (c_fill !== 8'd16) begin failures++; $display("FAIL push_pop_fill got=%0d want=16", c_fill); end
  endtask

  task automatic test_beat_order();
    logic [3:0] exp;
    sel = 0;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) begin
        exp = 4'((gw[j] >> (12 - 4 * k)) & 16'h000F);
        checks++;
        if (c_out !== 8'(exp)) begin
          failures++;
          $display("FAIL beat_w%0d_b%0d got=%h want=%h", j, k, c_out, exp);
        end
        shift_beat();
        if (j == 0 && k == 0) begin
          checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL xfer_d_ready got=%b want=0", c_d_ready); end
        end
      end
    end
    checks++; if (c_out !== 8'h00) begin failures++; $display("FAIL end_out_data got=%h want=00", c_out); end
    checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL end_d_ready got=%b want=0", c_d_ready); end
    checks++; if (c_fill !== 8'd1) begin failures++; $display("FAIL end_fill got=%0d want=1", c_fill); end
    en = 1'b0;
    step();
    checks++; if (c_fill !== 8'd0) begin failures++; $display("FAIL flush_fill got=%0d want=0", c_fill); end
    en = 1'b1;
    step();
  endtask

  task automatic test_underrun();
    sel = 0;
    shift_beat();
    checks++; if (c_underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got=%b want=1", c_underrun); end
    checks++; if (c_out !== 8'h00) begin failures++; $display("FAIL underrun_out got=%h want=00", c_out); end
    checks++; if (c_d_ready !== 1'b0) begin failures++; $display("FAIL underrun_d_ready got=%b want=0", c_d_ready); end
    for (int i = 0; i < 16; i++) push(16'h7E00 + 16'(i));
    wait_d_ready("underrun_chunk");
    checks++; if (c_underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%b want=1", c_underrun); end
    checks++; if (c_out !== 8'h07) begin failures++; $display("FAIL underrun_chunk_out got=%h want=07", c_out); end
    shift_beat(); shift_beat(); shift_beat();
    en = 1'b0;
    step();
    checks++; if (c_underrun !== 1'b0) begin failures++; $display("FAIL en_clear_underrun got=%b want=0", c_underrun); end
    checks++; if (c_d_ready !== 1'b0 || c_out !== 8'h00) begin failures++; $display("FAIL en_abort got d_ready=%b out=%h want 0/00", c_d_ready, c_out); end
    checks++; if (c_fill !== 8'd0 || c_wr_ready !== 1'b0) begin failures++; $display("FAIL en_idle got fill=%0d wr_ready=%b want 0/0", c_fill, c_wr_ready); end
    shift_beat();
    checks++; if (c_underrun !== 1'b0) begin failures++; $display("FAIL en0_shift_ignored got=%b want=0", c_underrun); end
    en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_xfer();
    sel = 0;
    shift_beat();
    for (int i = 0; i < 18; i++) push(16'h3300 + 16'(i));
    wait_d_ready("mid_xfer_chunk");
    for (int i = 0; i < 5; i++) shift_beat();
    #3;
    rst_ = 1'b0;
    #1;
    checks++; if (c_d_ready !== 1'b0 || c_out !== 8'h00) begin failures++; $display("FAIL async_rst_out got d_ready=%b out=%h want 0/00", c_d_ready, c_out); end
    checks++; if (c_fill !== 8'd0 || c_underrun !== 1'b0) begin failures++; $display("FAIL async_rst_state got fill=%0d underrun=%b want 0/0", c_fill, c_underrun); end
    checks++; if (c_wr_ready !== 1'b0) begin failures++; $display("FAIL async_rst_wr_ready got=%b want=0", c_wr_ready); end
    step();
    checks++; if (c_wr_ready !== 1'b0) begin failures++; $display("FAIL rst_hold_wr_ready got=%b want=0", c_wr_ready); end
    rst_ = 1'b1;
    #1;
    checks++; if (c_wr_ready !== 1'b1) begin failures++; $display("FAIL rst_release_wr_ready got=%b want=1", c_wr_ready); end
    step();
  endtask

  // Host model: starts a chunk only on an observed d_ready, shifts with random gaps, rebuilds words.
  task automatic test_stream(input int d, input int lanes, input bit lsb, input int chunk, input int nchunks,
                             input int hold, input int exp_acc, input int exp_fill, input string name);
    logic [15:0] words [$];
    logic [15:0] acc = '0;
    int total = chunk * nchunks;
    int beats = 16 / lanes;
    int sent = 0, rcvd = 0, beat_k = 0, left = 0, cyc = 0;
    bit do_push, do_shift, acc_push;
    sel = d;
    for (int i = 0; i < total; i++) words.push_back(16'($urandom));
    while (rcvd < total && cyc < 6000) begin
      if (hold > 0 && cyc == hold) begin
        checks++; if (sent != exp_acc) begin failures++; $display("FAIL %s_held_accepted got=%0d want=%0d", name, sent, exp_acc); end
        checks++; if (c_fill !== 8'(exp_fill)) begin failures++; $display("FAIL %s_held_fill got=%0d want=%0d", name, c_fill, exp_fill); end
        checks++; if (c_wr_ready !== 1'b0) begin failures++; $display("FAIL %s_held_wr_ready got=%b want=0", name, c_wr_ready); end
      end
      do_push = (sent < total);
      wr_valid = do_push;
      wr_data = do_push ? words[sent] : 16'h0000;
      if (left == 0 && c_d_ready && cyc >= hold) left = chunk * beats;
      do_shift = (left > 0) && ($urandom_range(0, 3) != 0);
      out_shift = do_shift;
      if (do_shift) begin
        if (lsb) acc = acc | (16'(c_out) << (lanes * beat_k));
        else     acc = (acc << lanes) | 16'(c_out);
        beat_k++;
        left--;
        if (beat_k == beats) begin
          checks++;
          if (acc !== words[rcvd]) begin
            failures++;
            $display("FAIL %s_word%0d got=%h want=%h", name, rcvd, acc, words[rcvd]);
          end
          rcvd++;
          beat_k = 0;
          acc = '0;
        end
      end
      acc_push = do_push && c_wr_ready;
      step();
      if (acc_push) sent++;
      cyc++;
    end
    wr_valid = 1'b0;
    out_shift = 1'b0;
    checks++; if (rcvd != total) begin failures++; $display("FAIL %s_timeout words got=%0d want=%0d", name, rcvd, total); end
    step(); step();
    checks++; if (c_fill !== 8'd0 || c_d_ready !== 1'b0) begin failures++; $display("FAIL %s_drained got fill=%0d d_ready=%b want 0/0", name, c_fill, c_d_ready); end
  endtask

  initial begin
    test_reset();
    test_chunk_gating();
    test_beat_order();
    test_underrun();
    test_reset_mid_xfer();
    test_stream(0, 4, 1'b0, 16, 5, 100, 65, 64, "full_a");
    test_stream(1, 1, 1'b1, 4, 4, 0, 0, 0, "lanes1");
    test_stream(2, 8, 1'b0, 4, 4, 20, 5, 4, "lanes8");
    test_stream(3, 2, 1'b1, 8, 4, 0, 0, 0, "lanes2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
